// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - effect codes, note table and scheduler state encoding
package sfx_pkg;

   localparam logic [2:0] SFX_NONE  = 3'd0;
   localparam logic [2:0] SFX_FLAP  = 3'd1;
   localparam logic [2:0] SFX_SCORE = 3'd2;
   localparam logic [2:0] SFX_COIN  = 3'd3;
   localparam logic [2:0] SFX_DIE   = 3'd4;

   // Half-periods in clk cycles at 100 MHz.
   localparam logic [16:0] HP_E6 = 17'd37908;
   localparam logic [16:0] HP_B5 = 17'd50607;
   localparam logic [16:0] HP_A5 = 17'd56818;
   localparam logic [16:0] HP_C5 = 17'd95602;
   localparam logic [16:0] HP_G4 = 17'd127551;

   localparam int NOTES_FLAP  = 2;
   localparam int NOTES_SCORE = 2;
   localparam int NOTES_COIN  = 3;
   localparam int NOTES_DIE   = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} sfx_state_t;

   typedef struct packed {
      logic [16:0] hp;
      logic [5:0]  dur;
   } note_t;

   function automatic note_t mk_note(input logic [16:0] hp, input logic [5:0] dur);
      note_t n;
      n.hp  = hp;
      n.dur = dur;
      return n;
   endfunction

   // Unused slots return a one-tick rest so a stray index can never stall.
   function automatic note_t sfx_note(input logic [2:0] sfx, input logic [1:0] idx);
      note_t n;
      n = mk_note(17'd0, 6'd1);
      case (sfx)
         SFX_FLAP:  case (idx)
                       2'd0:    n = mk_note(HP_E6, 6'd3);
                       2'd1:    n = mk_note(HP_B5, 6'd3);
                       default: n = mk_note(17'd0, 6'd1);
                    endcase
         SFX_SCORE: case (idx)
                       2'd0:    n = mk_note(HP_B5, 6'd5);
                       2'd1:    n = mk_note(HP_E6, 6'd10);
                       default: n = mk_note(17'd0, 6'd1);
                    endcase
         SFX_COIN:  case (idx)
                       2'd0:    n = mk_note(HP_A5, 6'd4);
                       2'd1:    n = mk_note(HP_B5, 6'd4);
                       2'd2:    n = mk_note(HP_E6, 6'd12);
                       default: n = mk_note(17'd0, 6'd1);
                    endcase
         SFX_DIE:   case (idx)
                       2'd0:    n = mk_note(HP_B5, 6'd10);
                       2'd1:    n = mk_note(HP_A5, 6'd10);
                       2'd2:    n = mk_note(HP_C5, 6'd10);
                       default: n = mk_note(HP_G4, 6'd30);
                    endcase
         default:   n = mk_note(17'd0, 6'd1);
      endcase
      return n;
   endfunction

   function automatic logic [1:0] sfx_last_idx(input logic [2:0] sfx);
      logic [1:0] r;
      case (sfx)
         SFX_FLAP:  r = 2'(NOTES_FLAP - 1);
         SFX_SCORE: r = 2'(NOTES_SCORE - 1);
         SFX_COIN:  r = 2'(NOTES_COIN - 1);
         SFX_DIE:   r = 2'(NOTES_DIE - 1);
         default:   r = 2'd0;
      endcase
      return r;
   endfunction

   // pending bit order {die, coin, score, flap}; codes grow with priority.
   function automatic logic [2:0] sfx_top(input logic [3:0] pend);
      logic [2:0] r;
      if (pend[3])      r = SFX_DIE;
      else if (pend[2]) r = SFX_COIN;
      else if (pend[1]) r = SFX_SCORE;
      else if (pend[0]) r = SFX_FLAP;
      else              r = SFX_NONE;
      return r;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave generator driven by a half-period count
// clk, clr (async, active-low) | load: restart with new hp | hp: half-period, 0 = rest | tone: square wave
module tone_gen (
   input  logic        clk,
   input  logic        clr,
   input  logic        load,
   input  logic [16:0] hp,
   output logic        tone
);

   logic [16:0] hp_q;
   logic [16:0] cnt;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         hp_q <= '0;
         cnt  <= '0;
         tone <= 1'b0;
      end else if (load) begin
         hp_q <= hp;
         cnt  <= '0;
         tone <= 1'b0;
      end else if (hp_q != 17'd0) begin
         if (cnt == hp_q - 17'd1) begin
            cnt  <= '0;
            tone <= ~tone;
         end else begin
            cnt <= cnt + 17'd1;
         end
      end
   end

endmodule

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - prioritised sound-effect sequencer owning the buzzer
// clk, clr (async, active-low) | evt_flap/score/coin/die: one-cycle requests | mute: silence audio
// audio: buzzer drive | busy: effect in PLAY or GAP | cur_sfx: 0 none, 1 flap, 2 score, 3 coin, 4 die
module sfx_scheduler
   import sfx_pkg::*;
#(
   parameter int TICK_CYCLES = 1000000,
   parameter int GAP_TICKS   = 1,
   parameter int HP_SHIFT    = 0
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       evt_flap,
   input  logic       evt_score,
   input  logic       evt_coin,
   input  logic       evt_die,
   input  logic       mute,
   output logic       audio,
   output logic       busy,
   output logic [2:0] cur_sfx
);

   localparam int            TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [5:0]    GAP_LAST  = 6'(GAP_TICKS - 1);

   sfx_state_t    state;
   logic [3:0]    pending;
   logic [1:0]    note_idx;
   logic [5:0]    cur_dur;
   logic [TW-1:0] tick_cnt;
   logic [5:0]    dur_cnt;

   logic [2:0]    top_sfx;
   logic          grant;
   logic [3:0]    grant_mask;
   logic [3:0]    evt_vec;
   note_t         note0;
   note_t         nxt;
   logic          last;
   logic [5:0]    seg_last;
   logic          seg_end;
   logic          play_done;
   logic          next_note;
   logic          load;
   logic [16:0]   load_hp;
   logic          tone;

   assign evt_vec = {evt_die, evt_coin, evt_score, evt_flap};
   assign top_sfx = sfx_top(pending);
   // cur_sfx is 0 in IDLE, so the same compare covers both a fresh grant and preemption.
   assign grant   = (top_sfx > cur_sfx);
   assign note0   = sfx_note(top_sfx, 2'd0);
   assign nxt     = sfx_note(cur_sfx, note_idx + 2'd1);
   assign last    = (note_idx == sfx_last_idx(cur_sfx));

   assign grant_mask = grant ? {top_sfx == SFX_DIE, top_sfx == SFX_COIN,
                                top_sfx == SFX_SCORE, top_sfx == SFX_FLAP} : 4'b0000;

   // PLAY and GAP share the prescaler and tick counter; only the segment length differs.
   assign seg_last  = (state == ST_GAP) ? GAP_LAST : (cur_dur - 6'd1);
   assign seg_end   = (state != ST_IDLE) && (tick_cnt == TICK_LAST) && (dur_cnt == seg_last);
   assign play_done = seg_end && (state == ST_PLAY) && last;
   assign next_note = seg_end && ((state == ST_GAP) || ((GAP_TICKS == 0) && !last));

   // The tone generator is reloaded on every state change; entering GAP or IDLE loads a rest.
   always_comb begin
      load    = 1'b0;
      load_hp = '0;
      if (grant) begin
         load    = 1'b1;
         load_hp = note0.hp >> HP_SHIFT;
      end else if (seg_end) begin
         load = 1'b1;
         if (next_note) load_hp = nxt.hp >> HP_SHIFT;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= ST_IDLE;
         pending  <= '0;
         note_idx <= '0;
         cur_dur  <= '0;
         tick_cnt <= '0;
         dur_cnt  <= '0;
         busy     <= 1'b0;
         cur_sfx  <= SFX_NONE;
      end else begin
         // A new event in the granting cycle re-arms its bit.
         pending <= (pending & ~grant_mask) | evt_vec;
         if (grant) begin
            state    <= ST_PLAY;
            cur_sfx  <= top_sfx;
            note_idx <= 2'd0;
            cur_dur  <= note0.dur;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            busy     <= 1'b1;
         end else if (play_done) begin
            state    <= ST_IDLE;
            cur_sfx  <= SFX_NONE;
            note_idx <= 2'd0;
            cur_dur  <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            busy     <= 1'b0;
         end else if (next_note) begin
            state    <= ST_PLAY;
            note_idx <= note_idx + 2'd1;
            cur_dur  <= nxt.dur;
            tick_cnt <= '0;
            dur_cnt  <= '0;
         end else if (seg_end) begin
            state    <= ST_GAP;
            tick_cnt <= '0;
            dur_cnt  <= '0;
         end else if (state != ST_IDLE) begin
            if (tick_cnt == TICK_LAST) begin
               tick_cnt <= '0;
               dur_cnt  <= dur_cnt + 6'd1;
            end else begin
               tick_cnt <= tick_cnt + 1'b1;
            end
         end
      end
   end

   tone_gen u_tone (
      .clk  (clk),
      .clr  (clr),
      .load (load),
      .hp   (load_hp),
      .tone (tone)
   );

   assign audio = tone & ~mute;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - self-checking bench for sfx_scheduler
module tb_sfx_scheduler;

   localparam int TC = 4;
   localparam int GT = 1;
   localparam int HS = 12;

   logic       clk;
   logic       clr;
   logic       evt_flap;
   logic       evt_score;
   logic       evt_coin;
   logic       evt_die;
   logic       mute;
   logic       audio;
   logic       busy;
   logic [2:0] cur_sfx;

   sfx_scheduler #(.TICK_CYCLES(TC), .GAP_TICKS(GT), .HP_SHIFT(HS)) dut (
      .clk       (clk),
      .clr       (clr),
      .evt_flap  (evt_flap),
      .evt_score (evt_score),
      .evt_coin  (evt_coin),
      .evt_die   (evt_die),
      .mute      (mute),
      .audio     (audio),
      .busy      (busy),
      .cur_sfx   (cur_sfx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Effect table: index 1 flap, 2 score, 3 coin, 4 die.
   int t_n[5]      = '{0, 2, 2, 3, 4};
   int t_raw[5][4] = '{'{0, 0, 0, 0},
                       '{37908, 50607, 0, 0},
                       '{50607, 37908, 0, 0},
                       '{56818, 50607, 37908, 0},
                       '{50607, 56818, 95602, 127551}};
   int t_dur[5][4] = '{'{0, 0, 0, 0},
                       '{3, 3, 0, 0},
                       '{5, 10, 0, 0},
                       '{4, 4, 12, 0},
                       '{10, 10, 10, 30}};

   function automatic int fx_total(input int c);
      int t;
      t = (t_n[c] - 1) * GT * TC;
      for (int k = 0; k < t_n[c]; k++) t += t_dur[c][k] * TC;
      return t;
   endfunction

   // Square-wave level e cycles after the effect was granted.
   function automatic int fx_tone(input int c, input int e);
      int r;
      int hp;
      r = e;
      for (int k = 0; k < t_n[c]; k++) begin
         if (r < t_dur[c][k] * TC) begin
            hp = t_raw[c][k] >> HS;
            return (hp == 0) ? 0 : ((r / hp) % 2);
         end
         r -= t_dur[c][k] * TC;
         if (r < GT * TC) return 0;
         r -= GT * TC;
      end
      return 0;
   endfunction

   bit [4:0] m_pend;
   int       m_cur;
   int       m_el;

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         m_pend = '0;
         m_cur  = 0;
         m_el   = 0;
      end else begin
         int top;
         top = 0;
         for (int c = 4; c >= 1; c--) if (m_pend[c] && top == 0) top = c;
         if (top > m_cur) begin
            m_cur = top;
            m_el  = 0;
            m_pend[top] = 1'b0;
         end else if (m_cur != 0) begin
            m_el++;
            if (m_el == fx_total(m_cur)) begin
               m_cur = 0;
               m_el  = 0;
            end
         end
         if (evt_flap)  m_pend[1] = 1'b1;
         if (evt_score) m_pend[2] = 1'b1;
         if (evt_coin)  m_pend[3] = 1'b1;
         if (evt_die)   m_pend[4] = 1'b1;
      end
   end

   always @(negedge clk) begin
      int e_audio;
      e_audio = (m_cur != 0 && !mute) ? fx_tone(m_cur, m_el) : 0;
      chk("cyc_busy", int'(busy), (m_cur != 0) ? 1 : 0);
      chk("cyc_cur_sfx", int'(cur_sfx), m_cur);
      chk("cyc_audio", int'(audio), e_audio);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_evt(input logic [3:0] m);
      {evt_die, evt_coin, evt_score, evt_flap} = m;
   endtask

   task automatic pulse(input logic [3:0] m);
      set_evt(m);
      tick();
      set_evt(4'b0000);
   endtask

   task automatic start_fx(input logic [3:0] m);
      pulse(m);
      tick();
   endtask

   int seq[$];
   int gaps[$];
   int want[$];

   // Logs the order of effects and the idle runs between them until the scheduler
   // has been idle for 5 cycles; optionally injects one event pulse at cycle inj_at.
   task automatic record_seq(input int inj_at, input logic [3:0] inj_mask);
      int prev;
      int idle;
      int run;
      int cyc;
      prev = 0;
      idle = 0;
      run  = 0;
      cyc  = 0;
      seq.delete();
      gaps.delete();
      while (idle < 5 && cyc < 3000) begin
         if (busy) begin
            if (run > 0 && seq.size() > 0) gaps.push_back(run);
            run  = 0;
            idle = 0;
            if (int'(cur_sfx) != prev) seq.push_back(int'(cur_sfx));
         end else begin
            run++;
            idle++;
         end
         prev = int'(cur_sfx);
         if (cyc == inj_at) set_evt(inj_mask);
         if (cyc == inj_at + 1) set_evt(4'b0000);
         tick();
         cyc++;
      end
      chk("record_bound", (cyc < 3000) ? 1 : 0, 1);
   endtask

   task automatic chk_list(input string nm, input bit use_gaps);
      int got[$];
      if (use_gaps) got = gaps;
      else          got = seq;
      chk($sformatf("%s_len", nm), got.size(), want.size());
      for (int i = 0; i < want.size() && i < got.size(); i++)
         chk($sformatf("%s_%0d", nm, i), got[i], want[i]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int first_hi;
      int hi;

      clr  = 1'b0;
      mute = 1'b0;
      set_evt(4'b0000);

      // Reset held with events arriving.
      repeat (3) tick();
      pulse(4'b1111);
      chk("rst_audio", int'(audio), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cur_sfx", int'(cur_sfx), 0);
      tick();
      clr = 1'b1;
      repeat (5) tick();
      chk("rst_no_pending", int'(busy), 0);

      // Single flap: latency, length, first toggle, high count.
      pulse(4'b0001);
      chk("flap_lat_pending", int'(busy), 0);
      tick();
      chk("flap_lat_busy", int'(busy), 1);
      chk("flap_cur_sfx", int'(cur_sfx), 1);
      cyc = 0; first_hi = -1; hi = 0;
      while (busy && cyc < 200) begin
         tick();
         cyc++;
         if (audio) begin
            hi++;
            if (first_hi < 0) first_hi = cyc;
         end
      end
      chk("flap_busy_len", cyc, 28);
      chk("flap_first_toggle", first_hi, 9);
      chk("flap_high_cycles", hi, 3);
      repeat (3) tick();

      // Preemption of coin by die.
      start_fx(4'b0100);
      chk("pre_coin", int'(cur_sfx), 3);
      repeat (6) tick();
      set_evt(4'b1000);
      tick();
      set_evt(4'b0000);
      chk("pre_still_coin", int'(cur_sfx), 3);
      tick();
      chk("pre_die", int'(cur_sfx), 4);
      cyc = 0; first_hi = -1;
      while (cur_sfx == 3'd4 && cyc < 400) begin
         tick();
         cyc++;
         if (audio && first_hi < 0) first_hi = cyc;
      end
      chk("pre_die_len", cyc, 252);
      chk("pre_die_first_toggle", first_hi, 12);
      repeat (3) tick();
      chk("pre_coin_not_resumed", int'(busy), 0);

      // Queuing: flap re-pended early, score landing on flap's final edge.
      start_fx(4'b0001);
      pulse(4'b0001);
      record_seq(26, 4'b0010);
      want = {1, 2, 1};
      chk_list("queue_order", 1'b0);
      want = {1, 1};
      chk_list("queue_gaps", 1'b1);

      // All four requested in one cycle.
      pulse(4'b1111);
      record_seq(-1, 4'b0000);
      want = {4, 3, 2, 1};
      chk_list("simul_order", 1'b0);
      want = {1, 1, 1};
      chk_list("simul_gaps", 1'b1);

      // Mute during coin.
      start_fx(4'b0100);
      mute = 1'b1;
      cyc = 0; hi = 0;
      while (busy && cyc < 500) begin
         tick();
         cyc++;
         if (audio) hi++;
      end
      mute = 1'b0;
      chk("mute_busy_len", cyc, 88);
      chk("mute_high_cycles", hi, 0);
      repeat (3) tick();

      // Asynchronous reset mid-note while the tone is high.
      start_fx(4'b0100);
      repeat (14) tick();
      chk("mid_pre_audio", int'(audio), 1);
      #2;
      clr = 1'b0;
      #1;
      chk("mid_async_audio", int'(audio), 0);
      chk("mid_async_busy", int'(busy), 0);
      chk("mid_async_cur_sfx", int'(cur_sfx), 0);
      tick();
      pulse(4'b1000);
      tick();
      clr = 1'b1;
      repeat (5) tick();
      chk("mid_no_pending_busy", int'(busy), 0);
      chk("mid_no_pending_sfx", int'(cur_sfx), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
